// File: rtl/arranque_pkg.sv
// Shared definitions for the staggered start-up release generator.
package arranque_pkg;

  // Sequencer states: hold count, staggered release, all released.
  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    ESCALONA = 2'd1,
    LISTO    = 2'd2
  } estado_t;

  // Counter width large enough to hold the larger of the two delays.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned stagger_cycles);
    int unsigned max_v;
    max_v = (hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/generador_arranque.sv
// Releases NUM_CH init flags in index order: first after HOLD_CYCLES edges,
// then one every STAGGER_CYCLES edges; listo marks the last release.
module generador_arranque
  import arranque_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reinicio,
  output logic [NUM_CH-1:0] ini,
  output logic              listo
);

  localparam int unsigned CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);

  // Reject parameter sets that cannot describe a release sequence.
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("generador_arranque: NUM_CH must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("generador_arranque: HOLD_CYCLES must be >= 1");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("generador_arranque: STAGGER_CYCLES must be >= 1");
  end

  estado_t           estado_q, estado_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [NUM_CH-1:0] ini_n;
  logic              listo_n;
  logic [NUM_CH-1:0] ini_sig;

  // Next thermometer value: one more channel released.
  assign ini_sig = (ini << 1) | NUM_CH'(1);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ESPERA;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_n;
      cnt_q    <= cnt_n;
    end
  end

  // Output registers; fed only from the registered next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ini   <= '0;
      listo <= 1'b0;
    end else begin
      ini   <= ini_n;
      listo <= listo_n;
    end
  end

  // Next-state, counter and next-output logic.
  always_comb begin
    estado_n = estado_q;
    cnt_n    = cnt_q;
    ini_n    = ini;
    listo_n  = listo;

    if (reinicio) begin
      estado_n = ESPERA;
      cnt_n    = '0;
      ini_n    = '0;
      listo_n  = 1'b0;
    end else begin
      unique case (estado_q)
        ESPERA: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            cnt_n    = '0;
            ini_n    = ini_sig;
            listo_n  = ini_sig[NUM_CH-1];
            estado_n = ini_sig[NUM_CH-1] ? LISTO : ESCALONA;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        ESCALONA: begin
          if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
            cnt_n    = '0;
            ini_n    = ini_sig;
            listo_n  = ini_sig[NUM_CH-1];
            estado_n = ini_sig[NUM_CH-1] ? LISTO : ESCALONA;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
        LISTO: begin
          cnt_n = '0;
        end
        default: begin
          estado_n = ESPERA;
          cnt_n    = '0;
          ini_n    = '0;
          listo_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_arranque.sv
// Directed bench for generador_arranque (3 ch, hold 4, stagger 2) plus a
// single-flag instance (1 ch, hold 1).
module tb_generador_arranque;

  localparam int unsigned N = 3;
  localparam int unsigned H = 4;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         reinicio;
  logic [N-1:0] ini;
  logic         listo;

  logic         rst_n1;
  logic         reinicio1;
  logic [0:0]   ini1;
  logic         listo1;

  int checks = 0;
  int errors = 0;

  generador_arranque #(.NUM_CH(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .reinicio(reinicio), .ini(ini), .listo(listo)
  );

  generador_arranque #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .reinicio(reinicio1), .ini(ini1), .listo(listo1)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected thermometer after edge e of a sequence.
  function automatic logic [31:0] exp_ini(input int e);
    int n;
    if (e < int'(H)) return 32'd0;
    n = (e - int'(H)) / int'(S) + 1;
    if (n > int'(N)) n = int'(N);
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic logic [31:0] exp_listo(input int e);
    return (e >= int'(H + (N - 1) * S)) ? 32'd1 : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_seq();
    rst_n = 1'b0;
    #3;
    chequear("rst_ini", 32'(ini), 32'd0);
    chequear("rst_listo", 32'(listo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run edges [from..to] of a sequence, checking every edge against the model.
  task automatic run_check(input string tag, input int from, input int to);
    for (int e = from; e <= to; e++) begin
      tick();
      chequear($sformatf("%s_ini_e%0d", tag, e), 32'(ini), exp_ini(e));
      chequear($sformatf("%s_listo_e%0d", tag, e), 32'(listo), exp_listo(e));
    end
  endtask

  initial begin
    rst_n = 1'b0; reinicio = 1'b0;
    rst_n1 = 1'b0; reinicio1 = 1'b0;
    #2;

    // Power-on sequence, stable through edge 50.
    reset_seq();
    run_check("pwr", 1, 50);

    // reinicio pulse after listo, sampled at edge 10.
    reset_seq();
    run_check("r28", 1, 9);
    reinicio = 1'b1;
    tick();
    chequear("r28_ini_e10", 32'(ini), 32'd0);
    chequear("r28_listo_e10", 32'(listo), 32'd0);
    reinicio = 1'b0;
    run_check("r28b", 1, 10);

    // reinicio pulse at edge 5 while only ini[0] is released.
    reset_seq();
    run_check("r29", 1, 4);
    reinicio = 1'b1;
    tick();
    chequear("r29_ini_e5", 32'(ini), 32'd0);
    reinicio = 1'b0;
    run_check("r29b", 1, 6);

    // Asynchronous reset 3 ns after edge 7.
    reset_seq();
    run_check("r30", 1, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chequear("r30_async_ini", 32'(ini), 32'd0);
    chequear("r30_async_listo", 32'(listo), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("r30b", 1, 10);

    // reinicio held for 20 edges after completion.
    reinicio = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chequear($sformatf("r31_hold_%0d", i), 32'({listo, ini}), 32'd0);
    end
    reinicio = 1'b0;
    run_check("r31b", 1, 8);

    // Single-flag instance: ini=listo=1 from the first edge after release.
    tick();
    chequear("one_rst_ini", 32'(ini1), 32'd0);
    chequear("one_rst_listo", 32'(listo1), 32'd0);
    @(negedge clk);
    rst_n1 = 1'b1;
    #1;
    chequear("one_pre_edge", 32'(ini1), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chequear($sformatf("one_ini_e%0d", i), 32'(ini1), 32'd1);
      chequear($sformatf("one_listo_e%0d", i), 32'(listo1), 32'd1);
    end
    reinicio1 = 1'b1;
    tick();
    chequear("one_reinicio", 32'({listo1, ini1}), 32'd0);
    reinicio1 = 1'b0;
    tick();
    chequear("one_after_reinicio", 32'({listo1, ini1}), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
